uart_rx_cfg: RTL and testbench
==============================

Name: uart_rx_cfg

Overview:
- Parametrised next-generation UART receiver: configurable data width, oversampling ratio, optional parity and 1 or 2 stop bits.
- Sits between the pad-side rx line and the baud-tick generator on one side, and a consumer with a valid/ready handshake on the other.
- Adds input synchronisation, false-start rejection, parity and framing checks, a held output word and overrun reporting.

Parameters:
- D_BIT, 8, data bits per frame (5..9), LSB first.
- OVERSAMPLE, 16, s_tick pulses per bit period (even, 8..32).
- STOP_BITS, 1, stop bits checked (1 or 2).
- PARITY_EN, 0, 1 = parity bit present after data.
- PARITY_ODD, 0, 0 = even parity, 1 = odd parity (ignored if PARITY_EN=0).

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- s_tick  in  1  oversample enable, one clk wide
- rx  in  1  asynchronous serial line, idle high
- rx_data  out  D_BIT  last received word
- rx_valid  out  1  rx_data holds an unconsumed word
- rx_ready  in  1  consumer accepts word when rx_valid&&rx_ready
- parity_err  out  1  parity mismatch for word in rx_data
- frame_err  out  1  a stop bit sampled low for word in rx_data
- overrun  out  1  one-cycle pulse: unconsumed word overwritten

Behaviour:
- Reset: state IDLE, all counters 0, rx_data=0, rx_valid=0, parity_err=0, frame_err=0, overrun=0, synchroniser flops and previous-sample flop =1.
- rx passes a 2-flop synchroniser; rxs denotes its output. All decisions use rxs.
- States: IDLE, START, DATA, PARITY, STOP. tick_cnt has width clog2(OVERSAMPLE); bit_cnt has width clog2(D_BIT); stop_cnt has width 1.
- IDLE -> START on a falling edge of rxs (prev=1, now=0), independent of s_tick; tick_cnt=0.
- Break behaviour: a line held low does not retrigger IDLE.
- START: on each s_tick, tick_cnt++. At the s_tick where tick_cnt==OVERSAMPLE/2-1:
  - rxs=1: false start; return to IDLE, no flags, no output change.
  - rxs=0: tick_cnt=0, bit_cnt=0, go to DATA.
- DATA: on each s_tick, tick_cnt++. At tick_cnt==OVERSAMPLE-1 (bit centre):
  - shift rxs in at the MSB (shift register moves right); tick_cnt=0.
  - After bit_cnt==D_BIT-1: go to PARITY if PARITY_EN, else STOP. Otherwise bit_cnt++.
- PARITY: sample at centre as above. Error if (XOR of data ^ sampled bit ^ PARITY_ODD)!=0; error is latched internally. Then go to STOP.
- STOP: sample at each stop-bit centre; any 0 latches the frame error. After the centre sample of the last stop bit (stop_cnt==STOP_BITS-1), commit and go to IDLE immediately. The rest of the stop bit is not waited for.
- Commit (clk after the committing s_tick):
  - rx_data <= shift register; parity_err and frame_err <= internal latches; rx_valid <= 1.
  - Internal latches clear at START entry.
  - Words with errors are still delivered.
- Handshake: rx_valid falls the clk after rx_valid&&rx_ready. rx_data and flags are held until the next commit.
- Overrun: if a commit occurs while rx_valid=1 and rx_ready=0, the new word overwrites the old one, rx_valid stays 1, and overrun pulses 1 cycle.
- Commit in the same cycle as rx_ready=1 is not an overrun; rx_valid stays 1 with the new word.
- No s_tick: FSM and counters hold.
- rst mid-frame: immediate return to reset values; a partial frame is discarded.
- Latency: a pin falling edge is detected 3 clk later.

Decomposition:
- Package uart_pkg: state enum (IDLE/START/DATA/PARITY/STOP) and a shared parity-compute function, reused by the future transmitter.
- Sub-module sync_2ff: generic 2-flop synchroniser, reset value parameter.

Test Plan:
- 8N1, OVERSAMPLE=16, send 0xA5, rx_ready=1 → one rx_valid pulse, rx_data=0xA5, parity_err=0, frame_err=0.
- PARITY_EN=1 even, send 0x3C with parity bit 1 → rx_data=0x3C, parity_err=1. Repeat with parity bit 0 → parity_err=0.
- 4-tick low glitch on idle line → no rx_valid, state returns to IDLE, flags unchanged.
- Send 0x55 with stop bit forced 0, then hold line low for 3 bit times → rx_data=0x55, frame_err=1, no second frame until rx rises and falls again.
- rx_ready=0, send 0x11 then 0x22 → rx_data=0x22, rx_valid=1, overrun pulses once. Raise rx_ready → rx_valid drops next clk.
- STOP_BITS=2, second stop bit 0, and assert rst mid-DATA of the following frame → frame_err=1 on the first word; after rst all outputs are 0 and the next clean 0x81 is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions.
//   uart_state_e : receiver FSM states.
//   parity_calc  : parity bit over up to MAX_D_BIT data bits.
//                  Zero-extend narrower words; odd=1 selects odd parity.
//                  The transmitter is meant to use the same function to
//                  generate its parity bit.
package uart_pkg;

  localparam int MAX_D_BIT = 9;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_e;

  function automatic logic parity_calc(input logic [MAX_D_BIT-1:0] data,
                                       input logic                 odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_rx_cfg_if.sv
// Consumer-side bundle of the UART receiver.
//   rx_data    : received word (held until next commit)
//   rx_valid   : rx_data holds an unconsumed word
//   rx_ready   : consumer accepts when rx_valid && rx_ready
//   parity_err : parity mismatch for the word in rx_data
//   frame_err  : a stop bit sampled low for the word in rx_data
//   overrun    : one-cycle pulse, unconsumed word overwritten
// master = receiver side, slave = consumer side.
interface uart_rx_cfg_if #(
  parameter int D_BIT = 8
);
  logic [D_BIT-1:0] rx_data;
  logic             rx_valid;
  logic             rx_ready;
  logic             parity_err;
  logic             frame_err;
  logic             overrun;

  modport master (
    output rx_data, rx_valid, parity_err, frame_err, overrun,
    input  rx_ready
  );

  modport slave (
    input  rx_data, rx_valid, parity_err, frame_err, overrun,
    output rx_ready
  );
endinterface

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for asynchronous inputs.
//   clk, rst : clock, asynchronous active-high reset
//   d        : asynchronous input
//   q        : synchronised output
// RST_VAL sets the reset value of both flops. For a serial line this is the
// idle level, so reset does not create a false edge.
module sync_2ff #(
  parameter int   WIDTH   = 1,
  parameter logic RST_VAL = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= {WIDTH{RST_VAL}};
      q    <= {WIDTH{RST_VAL}};
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver.
//   clk, rst : clock, asynchronous active-high reset
//   s_tick   : oversample enable, OVERSAMPLE pulses per bit period
//   rx       : asynchronous serial line, idle high, LSB first
//   bus      : consumer handshake (see uart_rx_cfg_if)
// Frame format: start, D_BIT data bits, optional parity, STOP_BITS stop bits.
// Words with parity or framing errors are still delivered, with flags set.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int D_BIT      = 8,
  parameter int OVERSAMPLE = 16,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          s_tick,
  input  logic          rx,
  uart_rx_cfg_if.master bus
);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(D_BIT);
  localparam logic [TW-1:0] T_HALF    = TW'(OVERSAMPLE/2 - 1);
  localparam logic [TW-1:0] T_FULL    = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_LAST    = BW'(D_BIT - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);
  localparam logic          ODD       = 1'(PARITY_ODD);

  logic rxs, rxs_prev;

  uart_state_e      state_q, state_d;
  logic [TW-1:0]    tick_q, tick_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic             stop_q, stop_d;
  logic [D_BIT-1:0] sh_q, sh_d;
  logic             perr_q, perr_d;   // error latches for the frame in flight
  logic             ferr_q, ferr_d;
  logic             commit;

  logic [D_BIT-1:0] data_q;
  logic             valid_q, perr_o, ferr_o, ovr_q;

  sync_2ff #(.WIDTH(1), .RST_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rxs)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      tick_q   <= '0;
      bit_q    <= '0;
      stop_q   <= 1'b0;
      sh_q     <= '0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
      rxs_prev <= 1'b1;
    end else begin
      state_q  <= state_d;
      tick_q   <= tick_d;
      bit_q    <= bit_d;
      stop_q   <= stop_d;
      sh_q     <= sh_d;
      perr_q   <= perr_d;
      ferr_q   <= ferr_d;
      rxs_prev <= rxs;
    end
  end

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    stop_d  = stop_q;
    sh_d    = sh_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        // Edge, not level: a line held low (break) never restarts a frame.
        if (rxs_prev && !rxs) begin
          state_d = START;
          tick_d  = '0;
          perr_d  = 1'b0;
          ferr_d  = 1'b0;
        end
      end
      START: begin
        if (s_tick) begin
          if (tick_q == T_HALF) begin
            if (rxs) begin
              state_d = IDLE;       // glitch shorter than half a bit
            end else begin
              tick_d  = '0;
              bit_d   = '0;
              state_d = DATA;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (tick_q == T_FULL) begin
            sh_d   = {rxs, sh_q[D_BIT-1:1]};
            tick_d = '0;
            if (bit_q == B_LAST) begin
              stop_d  = 1'b0;
              state_d = (PARITY_EN != 0) ? PARITY : STOP;
            end else begin
              bit_d = bit_q + 1'b1;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
      PARITY: begin
        if (s_tick) begin
          if (tick_q == T_FULL) begin
            perr_d  = parity_calc(MAX_D_BIT'(sh_q), ODD) ^ rxs;
            tick_d  = '0;
            state_d = STOP;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (tick_q == T_FULL) begin
            tick_d = '0;
            if (!rxs) ferr_d = 1'b1;
            // Commit at the centre of the last stop bit so a back-to-back
            // start bit is not missed.
            if (stop_q == STOP_LAST) begin
              commit  = 1'b1;
              state_d = IDLE;
            end else begin
              stop_d = stop_q + 1'b1;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output word register and handshake. A commit wins over a same-cycle
  // handshake, so rx_valid stays up with the new word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      perr_o  <= 1'b0;
      ferr_o  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      ovr_q <= 1'b0;
      if (commit) begin
        data_q  <= sh_q;
        perr_o  <= perr_q;
        ferr_o  <= ferr_d;              // includes the final stop sample
        valid_q <= 1'b1;
        ovr_q   <= valid_q && !bus.rx_ready;
      end else if (valid_q && bus.rx_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign bus.rx_data    = data_q;
  assign bus.rx_valid   = valid_q;
  assign bus.parity_err = perr_o;
  assign bus.frame_err  = ferr_o;
  assign bus.overrun    = ovr_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg. Three instances share clk/rst/s_tick:
//   0: 8N1, 1: 8E1, 2: 8N2 (all OVERSAMPLE=16, s_tick every 4 clk).
module tb_uart_rx_cfg;
  import uart_pkg::*;

  localparam int BIT = 64;   // clk per bit: 16 ticks * 4 clk

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic s_tick = 1'b0;
  logic rx_l    [3];
  logic ready_r [3];

  logic [7:0] data_w  [3];
  logic       valid_w [3];
  logic       perr_w  [3];
  logic       ferr_w  [3];
  logic       ovr_w   [3];

  int hs_cnt  [3];
  int ovr_cnt [3];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : gen_dut
    uart_rx_cfg_if #(.D_BIT(8)) bus ();
    assign bus.rx_ready = ready_r[g];
    assign data_w[g]    = bus.rx_data;
    assign valid_w[g]   = bus.rx_valid;
    assign perr_w[g]    = bus.parity_err;
    assign ferr_w[g]    = bus.frame_err;
    assign ovr_w[g]     = bus.overrun;

    uart_rx_cfg #(
      .D_BIT      (8),
      .OVERSAMPLE (16),
      .STOP_BITS  ((g == 2) ? 2 : 1),
      .PARITY_EN  ((g == 1) ? 1 : 0),
      .PARITY_ODD (0)
    ) u_dut (
      .clk    (clk),
      .rst    (rst),
      .s_tick (s_tick),
      .rx     (rx_l[g]),
      .bus    (bus)
    );
  end

  initial begin
    forever begin
      repeat (3) @(negedge clk);
      s_tick = 1'b1;
      @(negedge clk);
      s_tick = 1'b0;
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (valid_w[i] && ready_r[i]) hs_cnt[i]++;
      if (ovr_w[i]) ovr_cnt[i]++;
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic hold_bits(input int n);
    repeat (n * BIT) @(negedge clk);
  endtask

  // start, 8 data LSB first, optional parity, stop(s), optional low tail,
  // then two idle bit times.
  task automatic send(input int w, input logic [7:0] d, input bit par,
                      input logic pb, input logic s1, input logic s2,
                      input int nstop, input int tail_low);
    rx_l[w] = 1'b0; hold_bits(1);
    for (int i = 0; i < 8; i++) begin
      rx_l[w] = d[i]; hold_bits(1);
    end
    if (par) begin
      rx_l[w] = pb; hold_bits(1);
    end
    rx_l[w] = s1; hold_bits(1);
    if (nstop == 2) begin
      rx_l[w] = s2; hold_bits(1);
    end
    if (tail_low > 0) begin
      rx_l[w] = 1'b0; hold_bits(tail_low);
    end
    rx_l[w] = 1'b1; hold_bits(2);
  endtask

  typedef struct {
    int         w;
    logic [7:0] d;
    bit         par;
    logic       pb;
    logic       s1;
    logic       s2;
    int         nstop;
    logic [7:0] ed;
    logic       ep;
    logic       ef;
  } vec_t;

  vec_t vt [8];

  initial begin
    int h0, o0;

    vt[0] = '{0, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b1, 1, 8'hA5, 1'b0, 1'b0};
    vt[1] = '{1, 8'h3C, 1'b1, 1'b1, 1'b1, 1'b1, 1, 8'h3C, 1'b1, 1'b0};
    vt[2] = '{1, 8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, 1, 8'h3C, 1'b0, 1'b0};
    vt[3] = '{0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1, 8'h00, 1'b0, 1'b0};
    vt[4] = '{1, 8'h07, 1'b1, 1'b1, 1'b1, 1'b1, 1, 8'h07, 1'b0, 1'b0};
    vt[5] = '{1, 8'h07, 1'b1, 1'b1, 1'b0, 1'b1, 1, 8'h07, 1'b0, 1'b1};
    vt[6] = '{2, 8'hC3, 1'b0, 1'b0, 1'b0, 1'b1, 2, 8'hC3, 1'b0, 1'b1};
    vt[7] = '{2, 8'h5A, 1'b0, 1'b0, 1'b1, 1'b1, 2, 8'h5A, 1'b0, 1'b0};

    for (int i = 0; i < 3; i++) begin
      rx_l[i] = 1'b1; ready_r[i] = 1'b1; hs_cnt[i] = 0; ovr_cnt[i] = 0;
    end
    rst = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_outs%0d", i),
          int'({data_w[i], valid_w[i], perr_w[i], ferr_w[i], ovr_w[i]}), 0);
    end

    for (int i = 0; i < 8; i++) begin
      h0 = hs_cnt[vt[i].w];
      send(vt[i].w, vt[i].d, vt[i].par, vt[i].pb, vt[i].s1, vt[i].s2,
           vt[i].nstop, 0);
      chk($sformatf("v%0d_words", i), hs_cnt[vt[i].w] - h0, 1);
      chk($sformatf("v%0d_data", i), int'(data_w[vt[i].w]), int'(vt[i].ed));
      chk($sformatf("v%0d_perr", i), int'(perr_w[vt[i].w]), int'(vt[i].ep));
      chk($sformatf("v%0d_ferr", i), int'(ferr_w[vt[i].w]), int'(vt[i].ef));
    end

    // 4-tick glitch on idle line of instance 0: rejected as false start
    h0 = hs_cnt[0];
    rx_l[0] = 1'b0;
    repeat (16) @(negedge clk);
    rx_l[0] = 1'b1;
    hold_bits(3);
    chk("glitch_words", hs_cnt[0] - h0, 0);
    chk("glitch_valid", int'(valid_w[0]), 0);
    chk("glitch_data", int'(data_w[0]), 8'h00);
    chk("glitch_state", int'(gen_dut[0].u_dut.state_q), int'(IDLE));

    // stop bit low followed by a break: one word, no retrigger
    h0 = hs_cnt[0];
    send(0, 8'h55, 1'b0, 1'b0, 1'b0, 1'b1, 1, 3);
    hold_bits(12);
    chk("brk_words", hs_cnt[0] - h0, 1);
    chk("brk_data", int'(data_w[0]), 8'h55);
    chk("brk_ferr", int'(ferr_w[0]), 1);
    send(0, 8'h5A, 1'b0, 1'b0, 1'b1, 1'b1, 1, 0);
    chk("brk_next_words", hs_cnt[0] - h0, 2);
    chk("brk_next_data", int'(data_w[0]), 8'h5A);
    chk("brk_next_ferr", int'(ferr_w[0]), 0);

    // overrun
    ready_r[0] = 1'b0;
    o0 = ovr_cnt[0];
    send(0, 8'h11, 1'b0, 1'b0, 1'b1, 1'b1, 1, 0);
    chk("ovr_first_valid", int'(valid_w[0]), 1);
    chk("ovr_first_data", int'(data_w[0]), 8'h11);
    chk("ovr_first_pulse", ovr_cnt[0] - o0, 0);
    send(0, 8'h22, 1'b0, 1'b0, 1'b1, 1'b1, 1, 0);
    chk("ovr_second_valid", int'(valid_w[0]), 1);
    chk("ovr_second_data", int'(data_w[0]), 8'h22);
    chk("ovr_pulses", ovr_cnt[0] - o0, 1);
    ready_r[0] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("ovr_valid_drop", int'(valid_w[0]), 0);

    // 8N2, second stop bit low
    h0 = hs_cnt[2];
    send(2, 8'h81, 1'b0, 1'b0, 1'b1, 1'b0, 2, 0);
    chk("s2_words", hs_cnt[2] - h0, 1);
    chk("s2_data", int'(data_w[2]), 8'h81);
    chk("s2_ferr", int'(ferr_w[2]), 1);

    // reset in the middle of the data bits of the next frame
    rx_l[2] = 1'b0; hold_bits(1);
    rx_l[2] = 1'b1; hold_bits(2);
    rx_l[2] = 1'b0; hold_bits(1);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rx_l[2] = 1'b1;
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_outs",
        int'({data_w[2], valid_w[2], perr_w[2], ferr_w[2], ovr_w[2]}), 0);
    chk("mid_rst_state", int'(gen_dut[2].u_dut.state_q), int'(IDLE));
    hold_bits(2);
    h0 = hs_cnt[2];
    send(2, 8'h81, 1'b0, 1'b0, 1'b1, 1'b1, 2, 0);
    chk("post_rst_words", hs_cnt[2] - h0, 1);
    chk("post_rst_data", int'(data_w[2]), 8'h81);
    chk("post_rst_ferr", int'(ferr_w[2]), 0);
    chk("post_rst_perr", int'(perr_w[2]), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
